// File: rtl/hurricane_ctrl.sv
// Hurricane-mode supervisor: runs the timed hurricane phase, an optional menu
// grace period, locks out re-entry until power cycle, and accumulates run time.
module hurricane_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int RUN_SEC  = 60,
  parameter int MENU_SEC = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        machine_state,
  input  logic [2:0]  mode_state,
  input  logic        menu_btn,
  output logic        hurricane_mode_enabled,
  output logic        return_state,
  output logic [7:0]  countdown,
  output logic        countdown_active,
  output logic [15:0] cumulative_sec
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_MENU_WAIT,
    S_EXIT,
    S_LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cd_q, cd_d;
  logic          ret_q, ret_d;
  logic          en_q, act_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [PW-1:0] cpre_q, cpre_d;
  logic [15:0]   cum_q, cum_d;
  logic          menu_prev_q;

  logic menu_edge, tick, ctick, hur_sel, counted_mode;

  always_comb begin
    menu_edge    = menu_btn & ~menu_prev_q;
    tick         = (pre_q == PRE_MAX);
    ctick        = (cpre_q == PRE_MAX);
    hur_sel      = (mode_state == 3'b011);
    counted_mode = (mode_state == 3'b001) || (mode_state == 3'b010) ||
                   (mode_state == 3'b011);

    state_d = state_q;
    cd_d    = cd_q;
    ret_d   = ret_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;

    if (!machine_state) begin
      // Power-off is the only way out of LOCKED and overrides everything.
      state_d = S_IDLE;
      cd_d    = 8'd0;
      ret_d   = 1'b0;
      pre_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ret_d = 1'b0;
          cd_d  = 8'd0;
          pre_d = '0;
          if (hur_sel) begin
            state_d = S_RUN;
            cd_d    = 8'(RUN_SEC);
          end
        end
        S_RUN: begin
          if (!hur_sel) begin
            state_d = S_LOCKED;
            cd_d    = 8'd0;
            ret_d   = 1'b0;
            pre_d   = '0;
          end else if (menu_edge) begin
            state_d = S_MENU_WAIT;
            cd_d    = 8'(MENU_SEC);
            pre_d   = '0;
          end else if (tick) begin
            if (cd_q == 8'd1) begin
              state_d = S_EXIT;
              ret_d   = 1'b1;
              cd_d    = 8'd0;
            end else begin
              cd_d = cd_q - 8'd1;
            end
          end
        end
        S_MENU_WAIT: begin
          if (!hur_sel) begin
            state_d = S_LOCKED;
            cd_d    = 8'd0;
            ret_d   = 1'b0;
            pre_d   = '0;
          end else if (tick) begin
            if (cd_q == 8'd1) begin
              state_d = S_EXIT;
              ret_d   = 1'b0;
              cd_d    = 8'd0;
            end else begin
              cd_d = cd_q - 8'd1;
            end
          end
        end
        S_EXIT: begin
          pre_d = '0;
          if (!hur_sel) begin
            state_d = S_LOCKED;
            ret_d   = 1'b0;
          end
        end
        S_LOCKED: begin
          pre_d = '0;
          cd_d  = 8'd0;
          ret_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          cd_d    = 8'd0;
          ret_d   = 1'b0;
          pre_d   = '0;
        end
      endcase
    end

    cpre_d = ctick ? '0 : cpre_q + 1'b1;
    cum_d  = cum_q;
    if (ctick && machine_state && counted_mode && (cum_q != 16'hFFFF))
      cum_d = cum_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cd_q        <= 8'd0;
      ret_q       <= 1'b0;
      en_q        <= 1'b1;
      act_q       <= 1'b0;
      pre_q       <= '0;
      cpre_q      <= '0;
      cum_q       <= 16'd0;
      menu_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      ret_q       <= ret_d;
      en_q        <= (state_d != S_EXIT) && (state_d != S_LOCKED);
      act_q       <= (state_d == S_RUN) || (state_d == S_MENU_WAIT);
      pre_q       <= pre_d;
      cpre_q      <= cpre_d;
      cum_q       <= cum_d;
      menu_prev_q <= menu_btn;
    end
  end

  assign hurricane_mode_enabled = en_q;
  assign return_state           = ret_q;
  assign countdown              = cd_q;
  assign countdown_active       = act_q;
  assign cumulative_sec         = cum_q;

endmodule

// File: tb/tb_hurricane_ctrl.sv
// Self-checking bench for hurricane_ctrl: vector table, directed corner cases,
// and randomized traffic against a time-based reference model.
module tb_hurricane_ctrl;

  localparam int CLK_HZ = 4, RUN_SEC = 3, MENU_SEC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        machine_state = 1'b0;
  logic [2:0]  mode_state = 3'b000;
  logic        menu_btn = 1'b0;
  logic        en, ret, act;
  logic [7:0]  cd;
  logic [15:0] cum;

  int n_pass = 0, n_total = 0;

  hurricane_ctrl #(.CLK_HZ(CLK_HZ), .RUN_SEC(RUN_SEC), .MENU_SEC(MENU_SEC)) dut (
    .clk(clk), .rst(rst), .machine_state(machine_state), .mode_state(mode_state),
    .menu_btn(menu_btn), .hurricane_mode_enabled(en), .return_state(ret),
    .countdown(cd), .countdown_active(act), .cumulative_sec(cum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ms;
    logic [2:0] mode;
    logic       menu;
    logic       en;
    logic       ret;
    logic [7:0] cd;
    logic       act;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual !== expected)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ms, input logic [2:0] mode);
    @(negedge clk);
    rst = 1'b1;
    machine_state = ms;
    mode_state = mode;
    menu_btn = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Reference model: phases tracked by entry time and duration, countdown
  // derived arithmetically from elapsed cycles.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_MENU = 2, PH_EXIT = 3, PH_LOCK = 4;
  int   m_n, m_ph, m_t0, m_dur;
  logic m_ret, m_prev;
  int   m_cum;

  task automatic model_reset();
    m_n = 0; m_ph = PH_IDLE; m_t0 = 0; m_dur = 0;
    m_ret = 1'b0; m_prev = 1'b0; m_cum = 0;
  endtask

  task automatic model_edge(input logic ms, input logic [2:0] mode, input logic menu);
    logic ev;
    logic hur;
    ev = menu && !m_prev;
    m_prev = menu;
    hur = (mode == 3'd3);
    m_n++;
    if ((m_n % CLK_HZ) == 0 && ms && mode >= 3'd1 && mode <= 3'd3 && m_cum < 65535)
      m_cum++;
    if (!ms) begin
      m_ph = PH_IDLE; m_ret = 1'b0;
    end else begin
      case (m_ph)
        PH_IDLE: if (hur) begin m_ph = PH_RUN; m_t0 = m_n; m_dur = RUN_SEC; end
        PH_RUN: begin
          if (!hur) m_ph = PH_LOCK;
          else if (ev) begin m_ph = PH_MENU; m_t0 = m_n; m_dur = MENU_SEC; end
          else if (m_n - m_t0 >= m_dur * CLK_HZ) begin m_ph = PH_EXIT; m_ret = 1'b1; end
        end
        PH_MENU: begin
          if (!hur) m_ph = PH_LOCK;
          else if (m_n - m_t0 >= m_dur * CLK_HZ) begin m_ph = PH_EXIT; m_ret = 1'b0; end
        end
        PH_EXIT: if (!hur) m_ph = PH_LOCK;
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] model_cd();
    if (m_ph == PH_RUN || m_ph == PH_MENU)
      return 8'(m_dur - (m_n - m_t0) / CLK_HZ);
    return 8'd0;
  endfunction

  initial begin
    // Reset values, checked while reset is asserted.
    @(negedge clk);
    chk("reset_en", {31'd0, en}, 32'd1);
    chk("reset_ret", {31'd0, ret}, 32'd0);
    chk("reset_cd", {24'd0, cd}, 32'd0);
    chk("reset_act", {31'd0, act}, 32'd0);
    chk("reset_cum", {16'd0, cum}, 32'd0);

    // Vector table: full run to EXIT, lockout, power-cycle re-entry.
    for (int k = 0; k < 12; k++)
      vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'(3 - k / 4), 1'b1});
    vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1});

    do_reset(1'b1, 3'd0);
    foreach (vecs[i]) begin
      machine_state = vecs[i].ms;
      mode_state    = vecs[i].mode;
      menu_btn      = vecs[i].menu;
      step();
      chk($sformatf("vec%0d_en", i), {31'd0, en}, {31'd0, vecs[i].en});
      chk($sformatf("vec%0d_ret", i), {31'd0, ret}, {31'd0, vecs[i].ret});
      chk($sformatf("vec%0d_cd", i), {24'd0, cd}, {24'd0, vecs[i].cd});
      chk($sformatf("vec%0d_act", i), {31'd0, act}, {31'd0, vecs[i].act});
    end

    // Menu during RUN after one tick; second press in MENU_WAIT ignored.
    do_reset(1'b1, 3'd3);
    for (int k = 0; k < 5; k++) step();
    chk("menu_pre_cd", {24'd0, cd}, 32'd2);
    menu_btn = 1'b1; step();
    chk("menu_entry_cd", {24'd0, cd}, 32'd2);
    menu_btn = 1'b0; step();
    menu_btn = 1'b1; step();
    menu_btn = 1'b0; step();
    step();
    chk("menu_plus4_cd", {24'd0, cd}, 32'd1);
    for (int k = 0; k < 3; k++) step();
    chk("menu_plus7_en", {31'd0, en}, 32'd1);
    chk("menu_plus7_cd", {24'd0, cd}, 32'd1);
    step();
    chk("menu_exit_en", {31'd0, en}, 32'd0);
    chk("menu_exit_ret", {31'd0, ret}, 32'd0);
    chk("menu_exit_cd", {24'd0, cd}, 32'd0);

    // Reset mid-countdown: immediate reset values, no EXIT afterwards.
    do_reset(1'b1, 3'd3);
    for (int k = 0; k < 5; k++) step();
    chk("rstmid_pre_cd", {24'd0, cd}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rstmid_en", {31'd0, en}, 32'd1);
    chk("rstmid_cd", {24'd0, cd}, 32'd0);
    chk("rstmid_act", {31'd0, act}, 32'd0);
    for (int k = 0; k < 12; k++) @(posedge clk);
    @(negedge clk);
    chk("rstmid_hold_en", {31'd0, en}, 32'd1);
    chk("rstmid_hold_ret", {31'd0, ret}, 32'd0);
    rst = 1'b0;
    step();
    chk("rstmid_rerun_cd", {24'd0, cd}, 32'd3);

    // Cumulative seconds: count, hold over power-off, saturate.
    do_reset(1'b1, 3'd1);
    for (int k = 0; k < 40; k++) step();
    chk("cum_40cyc", {16'd0, cum}, 32'd10);
    machine_state = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("cum_off_hold", {16'd0, cum}, 32'd10);
    machine_state = 1'b1; mode_state = 3'd4;
    for (int k = 0; k < 8; k++) step();
    chk("cum_selfclean_hold", {16'd0, cum}, 32'd10);
    mode_state = 3'd2;
    force dut.cum_q = 16'hFFFF;
    #1;
    release dut.cum_q;
    for (int k = 0; k < 12; k++) step();
    chk("cum_saturate", {16'd0, cum}, 32'd65535);

    // Randomized traffic against the reference model.
    do_reset(1'b1, 3'd3);
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      machine_state = (r < 3) ? 1'b0 : 1'b1;
      r = $urandom_range(0, 99);
      if (r < 6) mode_state = 3'($urandom_range(0, 7));
      else if (r < 40) mode_state = 3'd3;
      if ($urandom_range(0, 5) == 0) menu_btn = ~menu_btn;
      step();
      model_edge(machine_state, mode_state, menu_btn);
      chk($sformatf("rnd%0d_en", c), {31'd0, en},
          {31'd0, (m_ph != PH_EXIT && m_ph != PH_LOCK)});
      chk($sformatf("rnd%0d_ret", c), {31'd0, ret},
          {31'd0, (m_ph == PH_EXIT) ? m_ret : 1'b0});
      chk($sformatf("rnd%0d_cd", c), {24'd0, cd}, {24'd0, model_cd()});
      chk($sformatf("rnd%0d_act", c), {31'd0, act},
          {31'd0, (m_ph == PH_RUN || m_ph == PH_MENU)});
      chk($sformatf("rnd%0d_cum", c), {16'd0, cum}, 32'(m_cum));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
